// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
//  Module   : regfile_wb_arbiter_pkg
//  Purpose  : Shared widths and helpers for the register-file writeback
//             arbiter slice (default requester count, register-file geometry,
//             round-robin pointer advance).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

// Register-file geometry shared with the register file itself. Guarded so a
// project-wide definition takes precedence.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif
`ifndef REG_FILE_NREG
`define REG_FILE_NREG 32
`endif

package regfile_wb_arbiter_pkg;

    localparam int c_N_REQ      = 3;
    localparam int c_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int c_DATA_WIDTH = `REG_FILE_WIDTH;
    localparam int c_NREG       = `REG_FILE_NREG;

    // Round-robin successor of a winner index. The wrap is explicit because
    // the requester count need not be a power of two.
    function automatic int rr_next(input int win, input int n);
        return (win == n - 1) ? 0 : win + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Bundle of writeback-request, issue-allocation, scoreboard and
//             register-file write signals around the writeback arbiter.
//  Ports    : req_valid/req_addr/req_data/req_ready  requester handshake
//             issue_en/issue_addr                     destination allocation
//             busy                                    pending-write mask
//             wrt_en/addrD/d                          register-file write port
//  Modports : master = execution units / issue stage side
//             slave  = arbiter side
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ      = c_N_REQ,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NREG       = c_NREG
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        issue_en;
    logic [ADDR_WIDTH-1:0]       issue_addr;
    logic [NREG-1:0]             busy;
    logic                        wrt_en;
    logic [ADDR_WIDTH-1:0]       addrD;
    logic [DATA_WIDTH-1:0]       d;

    modport master (
        output req_valid, req_addr, req_data, issue_en, issue_addr,
        input  req_ready, busy, wrt_en, addrD, d
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_en, issue_addr,
        output req_ready, busy, wrt_en, addrD, d
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches i_valid starting at
//             i_ptr, ascending and wrapping modulo N; the first set bit wins.
//  Ports    : i_valid  N       request vector
//             i_ptr    PTR_W   search start index (must be < N)
//             o_grant  N       one-hot grant (all zero when no request)
//             o_win    PTR_W   encoded winner index
//             o_any    1       at least one request present
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_valid,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant,
    output logic      [PTR_W-1:0] o_win,
    output logic                  o_any
);

    // One extra bit holds ptr+k before the modulo fold (max 2N-2).
    localparam logic [PTR_W:0] c_N = (PTR_W + 1)'(N);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && i_valid[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_win          = w_idx;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file's single write port among N_REQ
//             writeback requesters with round-robin arbitration, and keeps a
//             pending-write scoreboard for the issue stage's hazard stalls.
//             The register-file write port is driven from flops so address
//             and data are stable for a full cycle (the register file captures
//             the address on negedge and writes on posedge).
//  Ports    : clk   system clock, all state on posedge
//             rst   synchronous active-high reset
//             bus   regfile_wb_arbiter_if.slave (requests, issue, busy,
//                   wrt_en/addrD/d)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ      = c_N_REQ,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NREG       = c_NREG
) (
    input wire logic       clk,
    input wire logic       rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int c_PTR_W = $clog2(N_REQ);

    logic [c_PTR_W-1:0]    r_ptr;
    logic [N_REQ-1:0]      w_arb_grant;
    logic [c_PTR_W-1:0]    w_win;
    logic                  w_any;
    logic                  w_xfer;
    logic [c_PTR_W-1:0]    w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;

    logic                  r_wrt_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_set;
    logic [NREG-1:0]       w_clr;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_win   (w_win),
        .o_any   (w_any)
    );

    // The write port never stalls: any present request is granted, so a
    // transfer happens exactly when some request is valid outside reset.
    assign w_xfer        = w_any & ~rst;
    assign bus.req_ready = rst ? '0 : w_arb_grant;

    assign w_win_addr = bus.req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_data = bus.req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_nxt  = c_PTR_W'(rr_next(int'(w_win), N_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Write stage: one cycle from handshake to wrt_en. Address and data hold
    // across idle cycles so the register-file inputs never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrt_en <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_wrt_en <= w_xfer;
            if (w_xfer) begin
                r_addr <= w_win_addr;
                r_data <= w_win_data;
            end
        end
    end

    // Scoreboard. The clear is taken at the handshake, not at the register-
    // file write one cycle later; the issue-stage bypass covers that gap.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < NREG; r++) begin
            w_set[r] = bus.issue_en && (bus.issue_addr == ADDR_WIDTH'(r));
            w_clr[r] = w_xfer && (w_win_addr == ADDR_WIDTH'(r));
        end
    end

    // A new allocation wins over a same-cycle retirement of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.wrt_en = r_wrt_en;
    assign bus.addrD  = r_addr;
    assign bus.d      = r_data;

`ifndef SYNTHESIS
    // Requesters that were waiting (valid, not granted) last cycle must still
    // be valid now.
    logic [N_REQ-1:0] r_waiting;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waiting <= '0;
        end else begin
            r_waiting <= bus.req_valid & ~bus.req_ready;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ((r_waiting & ~bus.req_valid) == '0)
                else $error("requester dropped valid before its grant: %b",
                            r_waiting & ~bus.req_valid);
            if (w_xfer && !r_busy[w_win_addr]) begin
                $warning("writeback to register %0d with no pending write",
                         w_win_addr);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter: a table of per-cycle
//             stimulus/expected rows for reset and round-robin behaviour, then
//             hand-written sequences for latency, scoreboard and mid-op reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int c_NR = 3;
    localparam int c_AW = 5;
    localparam int c_DW = 32;
    localparam int c_NG = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(
        .N_REQ(c_NR), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NREG(c_NG)
    ) bus ();

    regfile_wb_arbiter #(
        .N_REQ(c_NR), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NREG(c_NG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [2:0]  rdy;   // expected req_ready this cycle
        logic        wrt;   // expected registered outputs after previous edge
        logic [4:0]  ad;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat(input int i, input int a);
        return 32'hC0DE_0000 + 32'(i * 256 + a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next posedge, apply inputs, then settle to a
    // sampling point mid-cycle.
    task automatic drive(input logic r, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic ie, input logic [4:0] ia);
        @(posedge clk);
        #1;
        rst            = r;
        bus.req_valid  = v;
        bus.req_addr   = {a2, a1, a0};
        bus.req_data   = {d2, d1, d0};
        bus.issue_en   = ie;
        bus.issue_addr = ia;
        #3;
    endtask

    task automatic add(input logic r, input logic [2:0] v, input int a0,
                       input int a1, input int a2, input logic [2:0] rdy,
                       input logic wrt, input int ad, input logic [31:0] d);
        vec_t t;
        t.rst = r;    t.valid = v;
        t.a0 = 5'(a0); t.a1 = 5'(a1); t.a2 = 5'(a2);
        t.rdy = rdy;  t.wrt = wrt;  t.ad = 5'(ad); t.d = d;
        vecs.push_back(t);
    endtask

    task automatic outs(input string tag, input logic wrt, input int ad,
                        input logic [31:0] d);
        chk({tag, " wrt_en"}, 64'(bus.wrt_en), 64'(wrt));
        chk({tag, " addrD"}, 64'(bus.addrD), 64'(ad));
        chk({tag, " d"}, 64'(bus.d), 64'(d));
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;

        // Reset with all requesters valid, then steady 3'b111 round-robin.
        add(1, 3'b111, 1, 2, 3, 3'b000, 0, 0, 32'h0);
        add(1, 3'b111, 1, 2, 3, 3'b000, 0, 0, 32'h0);
        add(0, 3'b111, 1, 2, 3, 3'b001, 0, 0, 32'h0);
        add(0, 3'b111, 1, 2, 3, 3'b010, 1, 1, dat(0, 1));
        add(0, 3'b111, 1, 2, 3, 3'b100, 1, 2, dat(1, 2));
        add(0, 3'b111, 1, 2, 3, 3'b001, 1, 3, dat(2, 3));
        add(0, 3'b111, 1, 2, 3, 3'b010, 1, 1, dat(0, 1));
        add(0, 3'b111, 1, 2, 3, 3'b100, 1, 2, dat(1, 2));
        // Drain the waiting requesters, then idle (addrD/d hold).
        add(0, 3'b011, 1, 2, 3, 3'b001, 1, 3, dat(2, 3));
        add(0, 3'b010, 1, 2, 3, 3'b010, 1, 1, dat(0, 1));
        add(0, 3'b000, 1, 2, 3, 3'b000, 1, 2, dat(1, 2));
        add(0, 3'b000, 1, 2, 3, 3'b000, 0, 2, dat(1, 2));
        // ptr=2: wrap to 0, skip to 1, sparse valids.
        add(0, 3'b011, 8, 9, 10, 3'b001, 0, 2, dat(1, 2));
        add(0, 3'b010, 8, 9, 10, 3'b010, 1, 8, dat(0, 8));
        add(0, 3'b101, 8, 9, 10, 3'b100, 1, 9, dat(1, 9));
        add(0, 3'b001, 8, 9, 10, 3'b001, 1, 10, dat(2, 10));
        add(0, 3'b000, 8, 9, 10, 3'b000, 1, 8, dat(0, 8));
        add(0, 3'b000, 8, 9, 10, 3'b000, 0, 8, dat(0, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].a0, vecs[i].a1,
                  vecs[i].a2, dat(0, int'(vecs[i].a0)),
                  dat(1, int'(vecs[i].a1)), dat(2, int'(vecs[i].a2)),
                  1'b0, 5'd0);
            chk($sformatf("row%0d ready", i), 64'(bus.req_ready),
                64'(vecs[i].rdy));
            outs($sformatf("row%0d", i), vecs[i].wrt, int'(vecs[i].ad),
                 vecs[i].d);
            chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'h0);
        end

        // Latency and data from requester 1 (ptr=1 here).
        drive(0, 3'b010, 0, 5, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("lat ready", 64'(bus.req_ready), 64'b010);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        outs("lat write", 1, 5, 32'hDEAD_BEEF);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        outs("lat idle", 0, 5, 32'hDEAD_BEEF);

        // Scoreboard on r7 (ptr=2), then an unrelated r12.
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7);
        drive(0, 3'b100, 0, 0, 7, 0, 0, dat(2, 7), 1, 7);
        chk("sb busy7 set", 64'(bus.busy), 64'h80);
        chk("sb grant7", 64'(bus.req_ready), 64'b100);
        drive(0, 3'b100, 0, 0, 7, 0, 0, dat(2, 7), 0, 0);
        chk("sb busy7 set wins", 64'(bus.busy), 64'h80);
        chk("sb regrant7", 64'(bus.req_ready), 64'b100);
        outs("sb w7", 1, 7, dat(2, 7));
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 12);
        chk("sb busy7 clear", 64'(bus.busy), 64'h0);
        drive(0, 3'b001, 12, 0, 0, dat(0, 12), 0, 0, 0, 0);
        chk("sb busy12 set", 64'(bus.busy), 64'h1000);
        chk("sb grant12", 64'(bus.req_ready), 64'b001);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sb busy12 clear", 64'(bus.busy), 64'h0);
        outs("sb w12", 1, 12, dat(0, 12));

        // Mid-operation reset (ptr=1 here; moves to 2 before reset).
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9);
        drive(0, 3'b010, 0, 11, 0, 0, dat(1, 11), 0, 0, 0);
        chk("mr grant1", 64'(bus.req_ready), 64'b010);
        chk("mr busy9", 64'(bus.busy), 64'h200);
        drive(1, 3'b110, 0, 11, 13, 0, dat(1, 11), dat(2, 13), 1, 20);
        chk("mr ready in rst", 64'(bus.req_ready), 64'b000);
        outs("mr pre", 1, 11, dat(1, 11));
        drive(0, 3'b110, 0, 11, 13, 0, dat(1, 11), dat(2, 13), 0, 0);
        chk("mr ptr reset grant", 64'(bus.req_ready), 64'b010);
        outs("mr post", 0, 0, 32'h0);
        chk("mr busy cleared", 64'(bus.busy), 64'h0);
        drive(0, 3'b100, 0, 0, 13, 0, 0, dat(2, 13), 0, 0);
        chk("mr grant2", 64'(bus.req_ready), 64'b100);
        outs("mr w11", 1, 11, dat(1, 11));
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        outs("mr w13", 1, 13, dat(2, 13));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
